// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate cache between the MEM stage
// and the SRAM controller, with true per-set LRU, a set-walking flush and saturating counters.
module assoc_cache_ctrl #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             flush,
    output logic [31:0]      read_data,
    output logic             ready,
    output logic [31:0]      sram_address,
    output logic [31:0]      sram_write_data,
    output logic             sram_wr_en,
    output logic             sram_rd_en,
    input  logic [63:0]      sram_read_data,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} state_t;
    state_t state, nextState;

    logic                  word;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    assign word  = address[2];
    assign index = address[3 +: INDEX_BITS];
    assign tag   = address[3+INDEX_BITS +: TAG_BITS];

    logic [63:0]           data0 [SETS];
    logic [63:0]           data1 [SETS];
    logic [TAG_BITS-1:0]   tag0  [SETS];
    logic [TAG_BITS-1:0]   tag1  [SETS];
    logic [SETS-1:0]       valid0, valid1, lru;
    logic [INDEX_BITS-1:0] flushPtr;

    logic        hit0, hit1, hit, hitWay, fillWay;
    logic [63:0] hitLine;
    assign hit0    = valid0[index] && (tag0[index] == tag);
    assign hit1    = valid1[index] && (tag1[index] == tag);
    assign hit     = hit0 || hit1;
    assign hitWay  = hit1;
    assign hitLine = hit1 ? data1[index] : data0[index];
    assign fillWay = lru[index];

    logic rdHit, fillDone, wrDone;
    assign rdHit    = (state == IDLE) && !flush && !wr_en && rd_en && hit;
    assign fillDone = (state == FILL) && sram_ready;
    assign wrDone   = (state == WRITE) && sram_ready;

    always_comb begin
        nextState       = state;
        ready           = 1'b0;
        read_data       = '0;
        sram_address    = '0;
        sram_write_data = '0;
        sram_rd_en      = 1'b0;
        sram_wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (flush)       nextState = FLUSH;
                else if (wr_en)  nextState = WRITE;
                else if (rd_en) begin
                    if (hit) begin
                        ready     = 1'b1;
                        read_data = word ? hitLine[63:32] : hitLine[31:0];
                    end else begin
                        nextState = FILL;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            FILL: begin
                sram_rd_en   = 1'b1;
                sram_address = {address[31:3], 3'b000};
                if (sram_ready) begin
                    ready     = 1'b1;
                    read_data = word ? sram_read_data[63:32] : sram_read_data[31:0];
                    nextState = IDLE;
                end
            end
            WRITE: begin
                sram_wr_en      = 1'b1;
                sram_address    = address;
                sram_write_data = write_data;
                if (sram_ready) begin
                    ready     = 1'b1;
                    nextState = IDLE;
                end
            end
            FLUSH: begin
                if (&flushPtr) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Reset must release the pipeline and the SRAM without waiting for a clock edge.
        if (!rst) begin
            ready      = 1'b1;
            sram_rd_en = 1'b0;
            sram_wr_en = 1'b0;
        end
    end

    // Data and tag arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fillDone) begin
            if (fillWay) begin
                data1[index] <= sram_read_data;
                tag1[index]  <= tag;
            end else begin
                data0[index] <= sram_read_data;
                tag0[index]  <= tag;
            end
        end
        if (wrDone && hit) begin
            if (hitWay) begin
                if (word) data1[index][63:32] <= write_data;
                else      data1[index][31:0]  <= write_data;
            end else begin
                if (word) data0[index][63:32] <= write_data;
                else      data0[index][31:0]  <= write_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid0     <= '0;
            valid1     <= '0;
            lru        <= '0;
            flushPtr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= nextState;
            if (rdHit) begin
                lru[index] <= ~hitWay;
                if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            end
            if (fillDone) begin
                if (fillWay) valid1[index] <= 1'b1;
                else         valid0[index] <= 1'b1;
                lru[index] <= ~fillWay;
                if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
            end
            if (wrDone && hit) lru[index] <= ~hitWay;
            // Pointer wraps to zero on the last set, ready for the next flush.
            if (state == FLUSH) begin
                valid0[flushPtr] <= 1'b0;
                valid1[flushPtr] <= 1'b0;
                lru[flushPtr]    <= 1'b0;
                flushPtr         <= flushPtr + 1'b1;
            end
        end
    end
endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised 2-way set-associative, write-through, no-write-allocate cache.
- Sits between the MEM stage and the SRAM controller.
- Successor to the fixed-size cache controller. Adds:
  - parametrised set count and tag width
  - line fill into the cache on a read miss
  - word update on a write hit
  - true per-set LRU replacement
  - a multi-cycle flush engine
  - saturating hit and miss performance counters

Parameters:
INDEX_BITS, 6, log2 of set count (SETS = 2^INDEX_BITS)
TAG_BITS, 10, tag width; address bits above 3+INDEX_BITS+TAG_BITS are ignored
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
address  in  32  byte address from the MEM stage
write_data  in  32  store data
wr_en  in  1  store request, held until ready
rd_en  in  1  load request, held until ready
flush  in  1  invalidate-all request, single-cycle pulse
read_data  out  32  load data, valid when ready=1 and rd_en=1
ready  out  1  request done or no request; 0 stalls the pipeline
sram_address  out  32  SRAM controller address
sram_write_data  out  32  SRAM store data
sram_wr_en  out  1  SRAM write, held until sram_ready
sram_rd_en  out  1  SRAM 64-bit line read, held until sram_ready
sram_read_data  in  64  line from SRAM: [31:0] = word 0, [63:32] = word 1
sram_ready  in  1  one-cycle SRAM completion pulse
hit_count  out  CNT_W  saturating read-hit count
miss_count  out  CNT_W  saturating read-miss count

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Address decode:
  - word = address[2]
  - index = address[3 +: INDEX_BITS]
  - tag = address[3+INDEX_BITS +: TAG_BITS]
- Storage per set: two 64-bit data lines, two tags, two valid bits, one lru bit (lru = way evicted next).
- Reset:
  - all valid and lru bits = 0; state = IDLE; counters = 0
  - data and tag arrays are not reset
  - outputs during reset: sram_rd_en=0, sram_wr_en=0, ready=1
  - reset mid-FILL/WRITE/FLUSH aborts immediately; SRAM enables drop asynchronously.
- Hit detection: hitN = validN[index] & (tagN[index] == tag). Combinational.
- State machine: IDLE, FILL, WRITE, FLUSH.
- IDLE:
  - No request: ready=1.
  - flush=1: go to FLUSH (priority over requests), ready=0.
  - wr_en=1: go to WRITE, ready=0. wr_en has priority if rd_en is also 1.
  - rd_en & hit:
    - ready=1 the same cycle; read_data = selected word of the hit way
    - at the edge: lru[index] <= ~hit_way; hit_count++
  - rd_en & miss: go to FILL, ready=0.
  - sram_ready is ignored.
- FILL:
  - sram_rd_en=1; sram_address = {address[31:3], 3'b000}.
  - On sram_ready:
    - write the line, tag and valid=1 into way lru[index], then flip lru[index]
    - read_data = word of sram_read_data; ready=1 that cycle
    - miss_count++; go to IDLE
  - Miss latency = 1 cycle + SRAM latency.
- WRITE:
  - sram_wr_en=1; sram_address = address; sram_write_data = write_data.
  - On sram_ready:
    - if hit: overwrite the addressed 32-bit word in the hit way; lru[index] <= ~hit_way
    - if miss: no allocation
    - ready=1; go to IDLE
  - Writes do not touch the counters.
- FLUSH:
  - 0..SETS-1 pointer clears valid0, valid1 and lru of one set per cycle; ready=0.
  - Returns to IDLE after the last set, i.e. SETS cycles.
  - flush outside IDLE is ignored.
- Requests must be held stable until ready=1.
- Counters saturate at all-ones. They are cleared only by rst, not by flush.

Test Plan:
- Cold read miss then hit:
  - Stimulus: after reset, read 0x0000_0104; SRAM returns 64'h2222_2222_1111_1111 after 3 cycles.
  - Response: sram_address=0x100; read_data=0x2222_2222 with ready on the sram_ready cycle.
  - Then read 0x100: ready the same cycle, read_data=0x1111_1111, hit_count=1, miss_count=1.
- LRU eviction:
  - Stimulus: fill 0x000 and 0x200 (both set 0); read 0x000; then read 0x400.
  - Response: 0x400 replaces the 0x200 way; 0x000 hits; 0x200 misses (sram_rd_en asserted).
- Write hit / write miss:
  - Stimulus: with 0x104 cached, write 0xDEAD_BEEF to 0x104.
  - Response: sram_wr_en held with address 0x104 until sram_ready; the next read of 0x104 hits with 0xDEAD_BEEF.
  - Stimulus: write to uncached 0x800.
  - Response: the next read of 0x800 misses.
- Flush:
  - Stimulus: with 0x000 and 0x104 cached, pulse flush.
  - Response: ready=0 for 64 cycles; reads of 0x000 and 0x104 then miss; counters unchanged by the flush.
- Async reset mid-fill:
  - Stimulus: drive rst=0 between clock edges while sram_rd_en=1.
  - Response: sram_rd_en=0 and ready=1 without a clock edge; after release, a read of a previously filled address misses; counters read 0.
- Saturation:
  - Stimulus: CNT_W=4; 17 read hits.
  - Response: hit_count=4'hF.
